// File: rtl/timekeeper_ctrl.sv
// Purpose : 1 Hz prescaler, time and alarm-time registers, adjust arbitration and alarm FSM.
// Latency : adjusts land on the next edge (or one cycle later if they collide with a tick update).
// Backpressure: none; a pulse colliding with the tick update waits in a 1-deep slot, further ones drop.
//
// Ports:
//   video_clk, reset (sync, active-high)
//   sec_adj / min_adj / hrs_adj : +1 on one field, wrapping without carry
//   al_adj                      : alarm time +AL_STEP_MIN with carry into al_hours
//   al_toggle / snooze          : arm-disarm / snooze while ringing
//   seconds, minutes, hours, al_minutes, al_hours : current register values
//   sec_tick, sec_phase         : 1 Hz pulse and 50%-duty 1 Hz square wave
//   al_on, ringing, buzzer_gate : alarm status and tone gate
module timekeeper_ctrl #(
  parameter int CLK_HZ       = 31_500_000,
  parameter int AL_STEP_MIN  = 10,
  parameter int SNOOZE_MIN   = 5,
  parameter int RING_TIMEOUT = 60
) (
  input  logic       video_clk,
  input  logic       reset,
  input  logic       sec_adj,
  input  logic       min_adj,
  input  logic       hrs_adj,
  input  logic       al_adj,
  input  logic       al_toggle,
  input  logic       snooze,
  output logic [5:0] seconds,
  output logic [5:0] minutes,
  output logic [3:0] hours,
  output logic [5:0] al_minutes,
  output logic [3:0] al_hours,
  output logic       sec_tick,
  output logic       sec_phase,
  output logic       al_on,
  output logic       ringing,
  output logic       buzzer_gate
);

  localparam int CW = $clog2(CLK_HZ);

  localparam logic [1:0] ST_OFF     = 2'd0;
  localparam logic [1:0] ST_ARMED   = 2'd1;
  localparam logic [1:0] ST_RINGING = 2'd2;
  localparam logic [1:0] ST_SNOOZED = 2'd3;

  function automatic logic [5:0] inc60(input logic [5:0] v);
    return (v == 6'd59) ? 6'd0 : v + 6'd1;
  endfunction

  function automatic logic [3:0] inc12(input logic [3:0] v);
    return (v == 4'd11) ? 4'd0 : v + 4'd1;
  endfunction

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q;
  logic [5:0]    sec_q, sec_d;
  logic [5:0]    min_q, min_d;
  logic [3:0]    hr_q, hr_d;
  logic          psec_q, psec_d;
  logic          pmin_q, pmin_d;
  logic          phr_q, phr_d;
  logic [5:0]    al_min_q, al_min_d;
  logic [3:0]    al_hr_q, al_hr_d;
  logic          min_evt_q;
  logic [1:0]    state_q, state_d;
  logic [7:0]    ring_cnt_q, ring_cnt_d;
  logic [11:0]   snz_cnt_q, snz_cnt_d;

  logic tick_min;
  logic tick_hr;
  logic match;

  // Prescaler; the tick register is loaded from the next count so it is high
  // exactly while cnt_q sits on its last value.
  assign cnt_d = (cnt_q == CW'(CLK_HZ - 1)) ? '0 : cnt_q + 1'b1;

  // Fields the tick update writes this cycle (seconds always).
  assign tick_min = tick_q & (sec_q == 6'd59);
  assign tick_hr  = tick_min & (min_q == 6'd59);

  always_comb begin
    sec_d  = sec_q;
    min_d  = min_q;
    hr_d   = hr_q;
    psec_d = psec_q;
    pmin_d = pmin_q;
    phr_d  = phr_q;

    // Tick update owns a field when it writes it; a colliding adjust is parked
    // and replayed next cycle. A pulse arriving while one is parked is lost.
    if (tick_q) begin
      sec_d = inc60(sec_q);
      if (sec_adj) psec_d = 1'b1;
    end else if (psec_q) begin
      sec_d  = inc60(sec_q);
      psec_d = 1'b0;
    end else if (sec_adj) begin
      sec_d = inc60(sec_q);
    end

    if (tick_min) begin
      min_d = inc60(min_q);
      if (min_adj) pmin_d = 1'b1;
    end else if (pmin_q) begin
      min_d  = inc60(min_q);
      pmin_d = 1'b0;
    end else if (min_adj) begin
      min_d = inc60(min_q);
    end

    if (tick_hr) begin
      hr_d = inc12(hr_q);
      if (hrs_adj) phr_d = 1'b1;
    end else if (phr_q) begin
      hr_d  = inc12(hr_q);
      phr_d = 1'b0;
    end else if (hrs_adj) begin
      hr_d = inc12(hr_q);
    end
  end

  // Alarm step in 6-bit arithmetic: the subtract of 60 wraps correctly because
  // the true result always lies in 0..59.
  always_comb begin
    al_min_d = al_min_q;
    al_hr_d  = al_hr_q;
    if (al_adj) begin
      if (al_min_q >= 6'(60 - AL_STEP_MIN)) begin
        al_min_d = al_min_q + 6'(AL_STEP_MIN) - 6'd60;
        al_hr_d  = inc12(al_hr_q);
      end else begin
        al_min_d = al_min_q + 6'(AL_STEP_MIN);
      end
    end
  end

  assign match = (hr_q == al_hr_q) && (min_q == al_min_q);

  // Alarm FSM; al_toggle beats every other event, snooze beats a tick.
  always_comb begin
    state_d    = state_q;
    ring_cnt_d = ring_cnt_q;
    snz_cnt_d  = snz_cnt_q;
    if (al_toggle) begin
      state_d = (state_q == ST_OFF) ? ST_ARMED : ST_OFF;
    end else begin
      case (state_q)
        ST_ARMED: begin
          if (min_evt_q && match) begin
            state_d    = ST_RINGING;
            ring_cnt_d = 8'd0;
          end
        end
        ST_RINGING: begin
          if (snooze) begin
            state_d   = ST_SNOOZED;
            snz_cnt_d = 12'(SNOOZE_MIN * 60);
          end else if (tick_q) begin
            if (ring_cnt_q == 8'(RING_TIMEOUT - 1)) state_d = ST_ARMED;
            else ring_cnt_d = ring_cnt_q + 8'd1;
          end
        end
        ST_SNOOZED: begin
          if (tick_q) begin
            if (snz_cnt_q == 12'd1) begin
              state_d    = ST_RINGING;
              ring_cnt_d = 8'd0;
            end else begin
              snz_cnt_d = snz_cnt_q - 12'd1;
            end
          end
        end
        default: state_d = ST_OFF;
      endcase
    end
  end

  always_ff @(posedge video_clk) begin
    if (reset) begin
      cnt_q      <= '0;
      tick_q     <= 1'b0;
      sec_q      <= 6'd0;
      min_q      <= 6'd0;
      hr_q       <= 4'd0;
      psec_q     <= 1'b0;
      pmin_q     <= 1'b0;
      phr_q      <= 1'b0;
      al_min_q   <= 6'd0;
      al_hr_q    <= 4'd0;
      min_evt_q  <= 1'b0;
      state_q    <= ST_OFF;
      ring_cnt_q <= 8'd0;
      snz_cnt_q  <= 12'd0;
    end else begin
      cnt_q      <= cnt_d;
      tick_q     <= (cnt_d == CW'(CLK_HZ - 1));
      sec_q      <= sec_d;
      min_q      <= min_d;
      hr_q       <= hr_d;
      psec_q     <= psec_d;
      pmin_q     <= pmin_d;
      phr_q      <= phr_d;
      al_min_q   <= al_min_d;
      al_hr_q    <= al_hr_d;
      min_evt_q  <= tick_min;
      state_q    <= state_d;
      ring_cnt_q <= ring_cnt_d;
      snz_cnt_q  <= snz_cnt_d;
    end
  end

  assign seconds    = sec_q;
  assign minutes    = min_q;
  assign hours      = hr_q;
  assign al_minutes = al_min_q;
  assign al_hours   = al_hr_q;
  assign sec_tick   = tick_q;
  // Prescaler is 0 while reset is held, so the phase is masked to keep the
  // output low during reset yet high from the very first cycle after release.
  assign sec_phase  = ~reset & (cnt_q < CW'(CLK_HZ / 2));
  assign al_on      = (state_q != ST_OFF);
  assign ringing    = (state_q == ST_RINGING);
  assign buzzer_gate = ringing & sec_phase;

endmodule

// File: tb/tb_timekeeper_ctrl.sv
module tb_timekeeper_ctrl;
  localparam int CLK_HZ = 10;
  localparam int AL_STEP = 10;
  localparam int SNZ_MIN = 1;
  localparam int RING_TO = 60;

  localparam logic [5:0] P_NONE = 6'b000000;
  localparam logic [5:0] P_SEC  = 6'b100000;
  localparam logic [5:0] P_MIN  = 6'b010000;
  localparam logic [5:0] P_HR   = 6'b001000;
  localparam logic [5:0] P_AL   = 6'b000100;
  localparam logic [5:0] P_TOG  = 6'b000010;
  localparam logic [5:0] P_SNZ  = 6'b000001;

  localparam int M_OFF = 0, M_ARMED = 1, M_RING = 2, M_SNZ = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sec_adj = 0, min_adj = 0, hrs_adj = 0, al_adj = 0, al_toggle = 0, snooze = 0;
  logic [5:0] seconds, minutes, al_minutes;
  logic [3:0] hours, al_hours;
  logic sec_tick, sec_phase, al_on, ringing, buzzer_gate;

  int n_checks = 0;
  int n_fail = 0;

  // Reference model state
  int cyc, m_sec, m_min, m_hr, al_tot, mode, ring_ticks, snz_left;
  bit p_sec, p_min, p_hr, m_evt;

  timekeeper_ctrl #(.CLK_HZ(CLK_HZ), .AL_STEP_MIN(AL_STEP), .SNOOZE_MIN(SNZ_MIN),
                    .RING_TIMEOUT(RING_TO)) dut (
    .video_clk(clk), .reset(reset), .sec_adj(sec_adj), .min_adj(min_adj),
    .hrs_adj(hrs_adj), .al_adj(al_adj), .al_toggle(al_toggle), .snooze(snooze),
    .seconds(seconds), .minutes(minutes), .hours(hours), .al_minutes(al_minutes),
    .al_hours(al_hours), .sec_tick(sec_tick), .sec_phase(sec_phase), .al_on(al_on),
    .ringing(ringing), .buzzer_gate(buzzer_gate));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    cyc = 0; m_sec = 0; m_min = 0; m_hr = 0; al_tot = 0; mode = M_OFF;
    ring_ticks = 0; snz_left = 0; p_sec = 0; p_min = 0; p_hr = 0; m_evt = 0;
  endtask

  // One clock of the spec's behaviour, from the pre-edge state and the pulses.
  task automatic model_update(input logic [5:0] p);
    bit tick, w_sec, w_min, w_hr;
    int tod, nsec, nmin, nhr;
    tick = (cyc % CLK_HZ) == CLK_HZ - 1;
    if (p[1]) mode = (mode == M_OFF) ? M_ARMED : M_OFF;
    else if (mode == M_ARMED) begin
      if (m_evt && (m_hr * 60 + m_min) == al_tot) begin mode = M_RING; ring_ticks = 0; end
    end else if (mode == M_RING) begin
      if (p[0]) begin mode = M_SNZ; snz_left = SNZ_MIN * 60; end
      else if (tick) begin
        ring_ticks++;
        if (ring_ticks == RING_TO) mode = M_ARMED;
      end
    end else if (mode == M_SNZ && tick) begin
      snz_left--;
      if (snz_left == 0) begin mode = M_RING; ring_ticks = 0; end
    end
    w_sec = tick;
    w_min = tick && m_sec == 59;
    w_hr  = w_min && m_min == 59;
    tod = m_hr * 3600 + m_min * 60 + m_sec;
    if (tick) tod = (tod + 1) % 43200;
    nhr = tod / 3600; nmin = (tod / 60) % 60; nsec = tod % 60;
    if (w_sec) begin if (p[5]) p_sec = 1; end
    else if (p_sec) begin nsec = (nsec + 1) % 60; p_sec = 0; end
    else if (p[5]) nsec = (nsec + 1) % 60;
    if (w_min) begin if (p[4]) p_min = 1; end
    else if (p_min) begin nmin = (nmin + 1) % 60; p_min = 0; end
    else if (p[4]) nmin = (nmin + 1) % 60;
    if (w_hr) begin if (p[3]) p_hr = 1; end
    else if (p_hr) begin nhr = (nhr + 1) % 12; p_hr = 0; end
    else if (p[3]) nhr = (nhr + 1) % 12;
    m_evt = w_min;
    if (p[2]) al_tot = (al_tot + AL_STEP) % 720;
    m_sec = nsec; m_min = nmin; m_hr = nhr;
    cyc++;
  endtask

  task automatic check_all();
    bit rst_now;
    rst_now = reset;
    chk("seconds", 16'(seconds), 16'(m_sec));
    chk("minutes", 16'(minutes), 16'(m_min));
    chk("hours", 16'(hours), 16'(m_hr));
    chk("al_minutes", 16'(al_minutes), 16'(al_tot % 60));
    chk("al_hours", 16'(al_hours), 16'(al_tot / 60));
    chk("sec_tick", 16'(sec_tick), 16'(!rst_now && (cyc % CLK_HZ) == CLK_HZ - 1));
    chk("sec_phase", 16'(sec_phase), 16'(!rst_now && (cyc % CLK_HZ) < CLK_HZ / 2));
    chk("al_on", 16'(al_on), 16'(mode != M_OFF));
    chk("ringing", 16'(ringing), 16'(mode == M_RING));
    chk("buzzer_gate", 16'(buzzer_gate),
        16'(mode == M_RING && !rst_now && (cyc % CLK_HZ) < CLK_HZ / 2));
  endtask

  task automatic step(input logic [5:0] p);
    {sec_adj, min_adj, hrs_adj, al_adj, al_toggle, snooze} = p;
    model_update(p);
    @(posedge clk); #1;
    {sec_adj, min_adj, hrs_adj, al_adj, al_toggle, snooze} = P_NONE;
    check_all();
  endtask

  task automatic do_reset();
    {sec_adj, min_adj, hrs_adj, al_adj, al_toggle, snooze} = P_NONE;
    reset = 1'b1;
    model_reset();
    repeat (2) begin @(posedge clk); #1; check_all(); end
    reset = 1'b0;
    #1 check_all();
  endtask

  // Idle until the DUT shows a tick cycle with the given seconds value.
  task automatic wait_tick_at(input int s);
    bit found = 0;
    for (int i = 0; i < 1000; i++) begin
      if (sec_tick === 1'b1 && seconds == 6'(s)) begin found = 1; break; end
      step(P_NONE);
    end
    chk("wait_tick_timeout", 16'(found), 16'd1);
  endtask

  task automatic set_hm(input int h, input int m);
    for (int i = 0; i < 300; i++) begin
      if (m_min == m && m_hr == h) break;
      if ((cyc % CLK_HZ) == CLK_HZ - 1) step(P_NONE);
      else if (m_min != m) step(P_MIN);
      else step(P_HR);
    end
    chk("set_hm_min", 16'(minutes), 16'(m));
    chk("set_hm_hr", 16'(hours), 16'(h));
  endtask

  // From ARMED with alarm 1:10, bring the clock to 1:10:00 and into RINGING.
  task automatic bring_to_ring();
    wait_tick_at(59);
    step(P_NONE);
    set_hm(1, 9);
    wait_tick_at(59);
    step(P_NONE);
    chk("pre_ring_ringing", 16'(ringing), 16'd0);
    step(P_NONE);
    chk("ring_start", 16'(ringing), 16'd1);
  endtask

  initial begin
    int tick_cyc[$];
    int mb, cnt;
    bit seen;
    logic [5:0] rp;

    // 1. prescaler and first ticks
    do_reset();
    chk("rst_seconds", 16'(seconds), 16'd0);
    chk("rst_al_on", 16'(al_on), 16'd0);
    for (int c = 0; c < 25; c++) begin
      if (sec_tick === 1'b1) tick_cyc.push_back(c);
      chk("s1_phase", 16'(sec_phase), 16'((c % 10) < 5));
      step(P_NONE);
    end
    chk("s1_tick_count", 16'(tick_cyc.size()), 16'd2);
    if (tick_cyc.size() == 2) begin
      chk("s1_tick0", 16'(tick_cyc[0]), 16'd9);
      chk("s1_tick1", 16'(tick_cyc[1]), 16'd19);
    end
    chk("s1_seconds", 16'(seconds), 16'd2);

    // 2. 11:59:59 rollover and seconds adjust wrap
    wait_tick_at(59);
    step(P_NONE);
    set_hm(11, 59);
    wait_tick_at(59);
    step(P_NONE);
    chk("s2_hours", 16'(hours), 16'd0);
    chk("s2_minutes", 16'(minutes), 16'd0);
    chk("s2_seconds", 16'(seconds), 16'd0);
    wait_tick_at(58);
    step(P_NONE);
    step(P_SEC);
    chk("s2_secadj_wrap", 16'(seconds), 16'd0);
    chk("s2_secadj_nocarry", 16'(minutes), 16'd0);

    // 3. min_adj colliding with carry, then a dropped second pulse
    wait_tick_at(59);
    mb = m_min;
    step(P_MIN);
    chk("s3_carry", 16'(minutes), 16'((mb + 1) % 60));
    step(P_MIN);
    chk("s3_pending", 16'(minutes), 16'((mb + 2) % 60));
    step(P_NONE);
    chk("s3_dropped", 16'(minutes), 16'((mb + 2) % 60));

    // 4. alarm set to 1:10 and triggered
    do_reset();
    repeat (7) step(P_AL);
    chk("s4_al_hours", 16'(al_hours), 16'd1);
    chk("s4_al_minutes", 16'(al_minutes), 16'd10);
    step(P_TOG);
    chk("s4_al_on", 16'(al_on), 16'd1);
    set_hm(1, 9);
    wait_tick_at(59);
    step(P_NONE);
    chk("s4_no_ring_yet", 16'(ringing), 16'd0);
    step(P_NONE);
    chk("s4_ringing", 16'(ringing), 16'd1);
    repeat (12) step(P_NONE);

    // 5. snooze for one minute, then ring timeout back to ARMED
    step(P_SNZ);
    chk("s5_snoozed", 16'(ringing), 16'd0);
    cnt = 0; seen = 0;
    for (int i = 0; i < 900; i++) begin
      if (ringing === 1'b1) begin seen = 1; break; end
      if (sec_tick === 1'b1) cnt++;
      step(P_NONE);
    end
    chk("s5_rering", 16'(seen), 16'd1);
    chk("s5_snooze_ticks", 16'(cnt), 16'(SNZ_MIN * 60));
    cnt = 0; seen = 0;
    for (int i = 0; i < 900; i++) begin
      if (ringing === 1'b0) begin seen = 1; break; end
      if (sec_tick === 1'b1) cnt++;
      step(P_NONE);
    end
    chk("s5_timeout_seen", 16'(seen), 16'd1);
    chk("s5_timeout_ticks", 16'(cnt), 16'(RING_TO));
    chk("s5_armed", 16'(al_on), 16'd1);
    repeat (30) step(P_NONE);
    chk("s5_no_retrigger", 16'(ringing), 16'd0);

    // 6. disarm while ringing, then reset while snoozed
    bring_to_ring();
    step(P_TOG);
    chk("s6_off_ringing", 16'(ringing), 16'd0);
    chk("s6_off_al_on", 16'(al_on), 16'd0);
    chk("s6_off_buzzer", 16'(buzzer_gate), 16'd0);
    step(P_TOG);
    bring_to_ring();
    step(P_SNZ);
    repeat (5) step(P_NONE);
    do_reset();
    chk("s6_rst_al_on", 16'(al_on), 16'd0);
    chk("s6_rst_al_minutes", 16'(al_minutes), 16'd0);
    repeat (15) step(P_NONE);

    // Randomised pulses against the model
    do_reset();
    step(P_TOG);
    for (int i = 0; i < 3000; i++) begin
      rp[5] = ($urandom_range(0, 11) == 0);
      rp[4] = ($urandom_range(0, 11) == 0);
      rp[3] = ($urandom_range(0, 15) == 0);
      rp[2] = ($urandom_range(0, 31) == 0);
      rp[1] = ($urandom_range(0, 199) == 0);
      rp[0] = ($urandom_range(0, 19) == 0);
      step(rp);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
